// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch sequencer, counter chain and bench.
// State encodings are fixed because the counter chain decodes them directly.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      LAP   = 2'd3
   } state_t;

   localparam int TICK_DIV_DEFAULT = 10;
   localparam int DEBOUNCE_DEFAULT = 4;

   function automatic logic isCounting(input state_t s);
      return (s == RUN) || (s == LAP);
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_cond.sv
// Push-button conditioner: debounces a raw button into a filtered level and
// emits a single-cycle press pulse on each accepted rising level.
module btn_cond
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int CNT_W = $clog2(DEBOUNCE + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

   logic             r_level;
   logic             r_levelQ;
   logic [CNT_W-1:0] r_cnt;

   // The level flips only after DEBOUNCE back-to-back disagreeing samples;
   // any agreeing sample restarts the run.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_level  <= 1'b0;
         r_levelQ <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_levelQ <= r_level;
         if (raw != r_level) begin
            if (r_cnt == CNT_LAST) begin
               r_level <= raw;
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign level = r_level;
   assign press = r_level & ~r_levelQ;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear sequencer for the stopwatch BCD counter chain: button
// conditioning, the control FSM and the count-enable prescaler.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEFAULT,
   parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_resume,
   input  logic       stop,
   input  logic       lap,
   output logic       tick_en,
   output logic       cnt_clr,
   output logic       disp_hold,
   output logic       running,
   output logic [1:0] state
);

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   state_t           r_state;
   logic [DIV_W-1:0] r_div;
   logic             r_cntClr;
   logic             r_dispHold;
   logic             r_running;

   logic w_startLevel, w_stopLevel, w_lapLevel;
   logic w_startPress, w_stopPress, w_lapPress;
   logic w_doStart, w_doStop, w_doLap;
   logic w_counting;

   btn_cond #(.DEBOUNCE(DEBOUNCE)) u_startBtn (
      .clk   (clk),
      .reset (reset),
      .raw   (start_resume),
      .level (w_startLevel),
      .press (w_startPress)
   );

   btn_cond #(.DEBOUNCE(DEBOUNCE)) u_stopBtn (
      .clk   (clk),
      .reset (reset),
      .raw   (stop),
      .level (w_stopLevel),
      .press (w_stopPress)
   );

   btn_cond #(.DEBOUNCE(DEBOUNCE)) u_lapBtn (
      .clk   (clk),
      .reset (reset),
      .raw   (lap),
      .level (w_lapLevel),
      .press (w_lapPress)
   );

   // Coinciding presses resolve as stop > start_resume > lap; losers are dropped.
   assign w_doStop   = w_stopPress;
   assign w_doStart  = w_startPress & ~w_stopPress;
   assign w_doLap    = w_lapPress & ~w_stopPress & ~w_startPress;
   assign w_counting = isCounting(r_state);

   // The prescaler advances on every counting edge, including the one that
   // leaves RUN/LAP, so the fraction held in PAUSE is what the next tick resumes from.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_div      <= '0;
         r_cntClr   <= 1'b0;
         r_dispHold <= 1'b0;
         r_running  <= 1'b0;
      end else begin
         r_cntClr <= 1'b0;
         if (w_counting) begin
            r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
         end
         case (r_state)
            IDLE: begin
               if (w_doStop) begin
                  r_cntClr <= 1'b1;
                  r_div    <= '0;
               end else if (w_doStart) begin
                  r_state   <= RUN;
                  r_running <= 1'b1;
               end
            end
            RUN: begin
               if (w_doStop) begin
                  r_state   <= PAUSE;
                  r_running <= 1'b0;
               end else if (w_doLap) begin
                  r_state    <= LAP;
                  r_dispHold <= 1'b1;
               end
            end
            LAP: begin
               if (w_doStop) begin
                  r_state    <= PAUSE;
                  r_running  <= 1'b0;
                  r_dispHold <= 1'b0;
               end else if (w_doLap) begin
                  r_state    <= RUN;
                  r_dispHold <= 1'b0;
               end
            end
            PAUSE: begin
               if (w_doStop) begin
                  r_state  <= IDLE;
                  r_cntClr <= 1'b1;
                  r_div    <= '0;
               end else if (w_doStart) begin
                  r_state   <= RUN;
                  r_running <= 1'b1;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_div      <= '0;
               r_dispHold <= 1'b0;
               r_running  <= 1'b0;
            end
         endcase
      end
   end

   assign tick_en   = w_counting & (r_div == DIV_LAST);
   assign cnt_clr   = r_cntClr;
   assign disp_hold = r_dispHold;
   assign running   = r_running;
   assign state     = r_state;

endmodule
